// File: rtl/approx_adder_eval_ctrl.sv
// Sweeps all 2^IN_W input vectors through an external combinational approximate adder and scores it against the exact sum.
// Latency: each vector is held SETTLE_CYC+1 cycles, so done pulses 2^IN_W*(SETTLE_CYC+1) cycles after start is taken.
// No backpressure: start is honoured only in IDLE, and abort drops an in-flight sweep while keeping the partial results.
module approx_adder_eval_ctrl #(
    parameter int IN_W       = 4,
    parameter int OUT_W      = 3,
    parameter int SETTLE_CYC = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    output logic [IN_W-1:0]         pi,
    input  logic [OUT_W-1:0]        po,
    output logic                    busy,
    output logic                    done,
    output logic [IN_W:0]           err_count,
    output logic [IN_W+OUT_W-1:0]   abs_err_sum,
    output logic [OUT_W-1:0]        max_abs_err,
    output logic [IN_W-1:0]         first_err_vec,
    output logic                    first_err_valid
);

    localparam int HALF   = IN_W / 2;
    localparam int WAIT_W = $clog2(SETTLE_CYC + 1);

    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(SETTLE_CYC);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [IN_W-1:0]   LAST_VEC  = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [IN_W-1:0]         r_vec;
    logic [WAIT_W-1:0]       r_wait;
    logic [IN_W:0]           r_err_count;
    logic [IN_W+OUT_W-1:0]   r_abs_err_sum;
    logic [OUT_W-1:0]        r_max_abs_err;
    logic [IN_W-1:0]         r_first_err_vec;
    logic                    r_first_err_valid;

    logic                    w_clear;
    logic                    w_do_sample;
    logic [OUT_W-1:0]        w_exact;
    logic [OUT_W-1:0]        w_err;

    // Exact reference sum and unsigned distance of the adder output from it.
    // Zero-extending each operand by one bit gives the OUT_W-bit sum, which cannot overflow.
    always_comb begin
        w_exact = {1'b0, r_vec[HALF-1:0]} + {1'b0, r_vec[IN_W-1:HALF]};
        if (po >= w_exact) begin
            w_err = po - w_exact;
        end else begin
            w_err = w_exact - po;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus the qualifiers that drive the datapath; abort beats a coincident sample.
    always_comb begin
        w_next      = r_state;
        w_clear     = 1'b0;
        w_do_sample = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next  = S_SETTLE;
                    w_clear = 1'b1;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (r_wait <= WAIT_ONE) begin
                    w_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else begin
                    w_do_sample = 1'b1;
                    w_next      = (r_vec == LAST_VEC) ? S_DONE : S_SETTLE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded from state; pi is forced to zero outside the sweep.
    always_comb begin
        busy = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
        done = (r_state == S_DONE);
        pi   = busy ? r_vec : '0;
    end

    // Vector/wait counters and the error accumulators.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vec             <= '0;
            r_wait            <= '0;
            r_err_count       <= '0;
            r_abs_err_sum     <= '0;
            r_max_abs_err     <= '0;
            r_first_err_vec   <= '0;
            r_first_err_valid <= 1'b0;
        end else begin
            if (w_clear) begin
                r_vec             <= '0;
                r_wait            <= WAIT_INIT;
                r_err_count       <= '0;
                r_abs_err_sum     <= '0;
                r_max_abs_err     <= '0;
                r_first_err_vec   <= '0;
                r_first_err_valid <= 1'b0;
            end
            if (r_state == S_SETTLE && !abort) begin
                r_wait <= r_wait - WAIT_ONE;
            end
            if (w_do_sample) begin
                if (w_err != '0) begin
                    r_err_count   <= r_err_count + (IN_W+1)'(1);
                    r_abs_err_sum <= r_abs_err_sum + {{IN_W{1'b0}}, w_err};
                    if (w_err > r_max_abs_err) begin
                        r_max_abs_err <= w_err;
                    end
                    if (!r_first_err_valid) begin
                        r_first_err_vec   <= r_vec;
                        r_first_err_valid <= 1'b1;
                    end
                end
                if (r_vec != LAST_VEC) begin
                    r_vec  <= r_vec + IN_W'(1);
                    r_wait <= WAIT_INIT;
                end
            end
        end
    end

    // Result ports.
    always_comb begin
        err_count       = r_err_count;
        abs_err_sum     = r_abs_err_sum;
        max_abs_err     = r_max_abs_err;
        first_err_vec   = r_first_err_vec;
        first_err_valid = r_first_err_valid;
    end

endmodule

// File: tb/tb_approx_adder_eval_ctrl.sv
// Bench for approx_adder_eval_ctrl: default instance (SETTLE_CYC=1) with a selectable faulty adder and a SETTLE_CYC=3 instance with an exact adder.
// Expected sweep results come from a reference model pushed onto a queue at start and popped when done appears.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_approx_adder_eval_ctrl;

    typedef struct packed {
        logic [4:0] cnt;
        logic [6:0] sum;
        logic [2:0] mx;
        logic [3:0] fv;
        logic       fvld;
    } res_t;

    logic       clk;
    logic       rst_n;
    logic       start_a, abort_a, start_b, abort_b;
    logic [3:0] pi_a, pi_b;
    logic [2:0] po_a, po_b;
    logic       busy_a, done_a, busy_b, done_b;
    logic [4:0] cnt_a, cnt_b;
    logic [6:0] sum_a, sum_b;
    logic [2:0] mx_a, mx_b;
    logic [3:0] fv_a, fv_b;
    logic       fvld_a, fvld_b;
    int         mode_a;

    int         tests = 0;
    int         fails = 0;
    res_t       exp_q[$];
    int         pi_q[$];

    approx_adder_eval_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .pi(pi_a), .po(po_a), .busy(busy_a), .done(done_a),
        .err_count(cnt_a), .abs_err_sum(sum_a), .max_abs_err(mx_a),
        .first_err_vec(fv_a), .first_err_valid(fvld_a)
    );

    approx_adder_eval_ctrl #(.IN_W(4), .OUT_W(3), .SETTLE_CYC(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .pi(pi_b), .po(po_b), .busy(busy_b), .done(done_b),
        .err_count(cnt_b), .abs_err_sum(sum_b), .max_abs_err(mx_b),
        .first_err_vec(fv_b), .first_err_valid(fvld_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder under evaluation: 0 exact, 1 sum bit 2 stuck at 0, 2 output stuck at 0.
    function automatic logic [2:0] adder(logic [3:0] v, int mode);
        logic [2:0] s;
        s = {1'b0, v[1:0]} + {1'b0, v[3:2]};
        if (mode == 1) s[2] = 1'b0;
        if (mode == 2) s = 3'd0;
        return s;
    endfunction

    always_comb po_a = adder(pi_a, mode_a);
    always_comb po_b = adder(pi_b, 0);

    // Reference scoring of vectors 0..last.
    function automatic res_t model(int mode, int last);
        res_t r;
        logic [3:0] v4;
        logic [2:0] ex, p, e;
        r = '0;
        for (int v = 0; v <= last; v++) begin
            v4 = 4'(v);
            ex = {1'b0, v4[1:0]} + {1'b0, v4[3:2]};
            p  = adder(v4, mode);
            e  = (p >= ex) ? p - ex : ex - p;
            if (e != 3'd0) begin
                r.cnt = r.cnt + 5'd1;
                r.sum = r.sum + {4'd0, e};
                if (e > r.mx) r.mx = e;
                if (!r.fvld) begin
                    r.fv   = v4;
                    r.fvld = 1'b1;
                end
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_results(input string tag, input bit use_b);
        res_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_cnt"},  use_b ? 32'(cnt_b)  : 32'(cnt_a),  32'(e.cnt));
            chk({tag, "_sum"},  use_b ? 32'(sum_b)  : 32'(sum_a),  32'(e.sum));
            chk({tag, "_max"},  use_b ? 32'(mx_b)   : 32'(mx_a),   32'(e.mx));
            chk({tag, "_fv"},   use_b ? 32'(fv_b)   : 32'(fv_a),   32'(e.fv));
            chk({tag, "_fvld"}, use_b ? 32'(fvld_b) : 32'(fvld_a), 32'(e.fvld));
        end
    endtask

    task automatic check_zero_a(input string tag);
        chk({tag, "_pi"},   32'(pi_a),   0);
        chk({tag, "_busy"}, 32'(busy_a), 0);
        chk({tag, "_done"}, 32'(done_a), 0);
        chk({tag, "_cnt"},  32'(cnt_a),  0);
        chk({tag, "_sum"},  32'(sum_a),  0);
        chk({tag, "_max"},  32'(mx_a),   0);
        chk({tag, "_fv"},   32'(fv_a),   0);
        chk({tag, "_fvld"}, 32'(fvld_a), 0);
    endtask

    // Full sweep on dut_a. Edge j=0 is the edge that samples start.
    task automatic run_a(input int mode, input bit with_abort, input bit extra_starts, input string tag);
        int done_edge, n_done, busy_cnt;
        mode_a  = mode;
        start_a = 1'b1;
        abort_a = with_abort;
        exp_q.push_back(model(mode, 15));
        done_edge = -1;
        n_done    = 0;
        busy_cnt  = 0;
        for (int j = 0; j < 60; j++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
            abort_a = 1'b0;
            if (j == 0) chk({tag, "_busy_after_start"}, 32'(busy_a), 1);
            if (busy_a) busy_cnt++;
            if (done_a) begin
                n_done++;
                if (done_edge < 0) done_edge = j;
            end
            if (extra_starts && (j == 3 || j == 10 || j == 31 || done_a)) start_a = 1'b1;
        end
        chk({tag, "_done_edge"}, 32'(done_edge), 32);
        chk({tag, "_done_count"}, 32'(n_done), 1);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32);
        chk({tag, "_pi_idle"}, 32'(pi_a), 0);
        check_results(tag, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int found, n_done, done_edge;
        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        mode_a = 0;
        repeat (2) @(posedge clk);
        #1;
        check_zero_a("reset");
        chk("reset_b_busy", 32'(busy_b), 0);
        chk("reset_b_pi", 32'(pi_b), 0);
        rst_n = 1'b1;

        // Exact adder with stray starts during busy and in DONE.
        run_a(0, 1'b0, 1'b1, "exact");
        // Start and abort together in IDLE: start wins.
        run_a(1, 1'b1, 1'b0, "stuck2");
        run_a(2, 1'b0, 1'b0, "zero");

        // Abort in SETTLE of vector 5: only vectors 0..4 are scored.
        @(posedge clk); #1;
        mode_a  = 2;
        start_a = 1'b1;
        exp_q.push_back(model(2, 4));
        found = 0;
        for (int j = 0; j < 40 && found == 0; j++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
            if (busy_a && pi_a == 4'd5) found = 1;
        end
        chk("abort_reach_vec5", 32'(found), 1);
        abort_a = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy_a), 0);
        chk("abort_pi", 32'(pi_a), 0);
        chk("abort_done", 32'(done_a), 0);
        // Abort held in IDLE must change nothing; no done may ever appear.
        n_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_a || busy_a) n_done++;
        end
        abort_a = 1'b0;
        chk("abort_no_done", 32'(n_done), 0);
        check_results("abort_partial", 1'b0);

        // SETTLE_CYC=3: each vector held 4 cycles, done after edge 64.
        start_b = 1'b1;
        for (int v = 0; v < 16; v++) repeat (4) pi_q.push_back(v);
        exp_q.push_back(model(0, 15));
        done_edge = -1;
        for (int j = 0; j < 80; j++) begin
            @(posedge clk); #1;
            start_b = 1'b0;
            if (pi_q.size() > 0) chk("s3_pi", 32'(pi_b), 32'(pi_q.pop_front()));
            if (done_b && done_edge < 0) done_edge = j;
        end
        chk("s3_done_edge", 32'(done_edge), 64);
        check_results("s3", 1'b1);

        // One-cycle reset mid-sweep, then a fresh full sweep.
        mode_a  = 2;
        start_a = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            start_a = 1'b0;
        end
        chk("midsweep_busy", 32'(busy_a), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_zero_a("midrst");
        rst_n = 1'b1;
        n_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_a) n_done++;
        end
        chk("midrst_no_done", 32'(n_done), 0);
        run_a(2, 1'b0, 1'b0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
